// File: rtl/freq_div_controller.sv
// freq_div_controller: programmable prescaler sequencer; one-cycle tick every div_q+1 clk cycles.
// Latency: first tick is registered div_q+1 edges after the start edge; done coincides with final one-shot tick.
// Backpressure: cfg_ready high only in IDLE; config offers and start are ignored while busy.
// Optional build: define FDC_SQUARE_OUT_EN to add sq_out, which toggles on every tick edge.
// Ports: clk/rstn (async active-low); cfg_valid/cfg_ready handshake carrying cfg_div, cfg_count, cfg_oneshot;
//        start/stop level requests; tick, tick_cnt, busy, done status outputs; sq_out (optional).
module freq_div_controller #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             busy,
  output logic             done
`ifdef FDC_SQUARE_OUT_EN
  ,
  output logic             sq_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] count_q;
  logic             oneshot_q;
  logic [CNT_W-1:0] tick_cnt_nxt;
  logic             period_end;
  logic             launch;

  assign tick_cnt_nxt = tick_cnt + CNT_W'(1);
  assign period_end   = (pcnt == div_q);
  // stop has priority over start in IDLE
  assign launch       = start && !stop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      div_q     <= '1;
      count_q   <= '0;
      oneshot_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tick <= 1'b0;
          // Config latched on the same edge as start applies to that run.
          if (cfg_valid) begin
            div_q     <= cfg_div;
            count_q   <= cfg_count;
            oneshot_q <= cfg_oneshot;
          end
          if (launch) begin
            state     <= S_RUN;
            pcnt      <= '0;
            tick_cnt  <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            // stop wins over a coincident terminal count: no tick, no done
            state     <= S_IDLE;
            tick      <= 1'b0;
            pcnt      <= '0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (period_end) begin
            pcnt     <= '0;
            tick     <= 1'b1;
            tick_cnt <= tick_cnt_nxt;
            // count_q==0 matches when the counter wraps, i.e. after 2^CNT_W ticks
            if (oneshot_q && (tick_cnt_nxt == count_q)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            pcnt <= pcnt + WIDTH'(1);
            tick <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          tick      <= 1'b0;
          pcnt      <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          tick      <= 1'b0;
          pcnt      <= '0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FDC_SQUARE_OUT_EN
  // Toggles on the same edge that raises tick; holds through stop and done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sq_out <= 1'b0;
    end else if (state == S_IDLE && launch) begin
      sq_out <= 1'b0;
    end else if (state == S_RUN && !stop && period_end) begin
      sq_out <= ~sq_out;
    end
  end
`endif

endmodule
